pdm_cic_decimator: RTL and testbench

PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

---
 rtl/pdm_cic_decimator_if.sv | 11 +
 rtl/pdm_cic_decimator.sv | 124 ++++++++++++
 tb/tb_pdm_cic_decimator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_cic_decimator_if.sv
// Bit-clock/bitstream and decimated-sample signals between the decimator and its environment.
// Signal names follow the device pinout rather than the _i/_o suffix scheme.
interface pdm_cic_decimator_if;
    logic               pdm_clk;
    logic               pdm_data;
    logic signed [15:0] pcm_out;
    logic               pcm_stb;

    modport master (output pdm_clk, input pdm_data, output pcm_out, output pcm_stb);
    modport slave  (input pdm_clk, output pdm_data, input pcm_out, input pcm_stb);
endinterface

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: bit-clock generator plus 3rd-order CIC decimate-by-64
// with 20-bit wrapping arithmetic, a /8 output scale and 16-bit saturation.
module pdm_cic_decimator #(
    parameter int unsigned PDM_HALF = 25
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    pdm_cic_decimator_if.master  bus
);
    localparam int       STAGES = 2;
    localparam logic [7:0] TC   = 8'(PDM_HALF - 1);

    logic [1:0]         rst_sync_q;
    logic [1:0]         din_sync_q;
    logic [7:0]         div_q;
    logic               pclk_q;
    logic [5:0]         dec_q;
    logic signed [19:0] integ_q [3];
    logic signed [19:0] dly_q [3];
    logic signed [19:0] acc_q;
    logic [STAGES:0]    vld_pipe_q;
    logic [1:0]         warm_q;
    logic signed [15:0] pcm_q;
    logic               stb_q;

    logic               run, samp, wrap;
    logic signed [19:0] x_s, int3_d, comb_out, comb_sh;
    logic signed [15:0] sat_d;

    // Release of rstn is retimed so every counter leaves reset on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
            din_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            din_sync_q <= {din_sync_q[0], bus.pdm_data};
        end
    end

    assign run    = en & rst_sync_q[1];
    // Last cycle of the high phase: data has had a full half period to settle.
    assign samp   = run & pclk_q & (div_q == TC);
    assign wrap   = samp & (dec_q == 6'd63);
    assign x_s    = din_sync_q[1] ? 20'sd1 : -20'sd1;
    assign int3_d = integ_q[2] + integ_q[1];

    always_comb begin
        comb_out = acc_q - dly_q[STAGES];
        comb_sh  = comb_out >>> 3;
        if (comb_sh > 20'sd32767)       sat_d = 16'sh7fff;
        else if (comb_sh < -20'sd32768) sat_d = 16'sh8000;
        else                            sat_d = comb_sh[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q      <= '0;
            pclk_q     <= 1'b0;
            dec_q      <= '0;
            acc_q      <= '0;
            vld_pipe_q <= '0;
            warm_q     <= '0;
            pcm_q      <= '0;
            stb_q      <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else if (!run) begin
            // Full restart; only the last published sample survives.
            div_q      <= '0;
            pclk_q     <= 1'b0;
            dec_q      <= '0;
            acc_q      <= '0;
            vld_pipe_q <= '0;
            warm_q     <= '0;
            stb_q      <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            stb_q <= 1'b0;
            if (div_q == TC) begin
                div_q  <= '0;
                pclk_q <= ~pclk_q;
            end else begin
                div_q <= div_q + 8'd1;
            end

            if (samp) begin
                integ_q[0] <= integ_q[0] + x_s;
                integ_q[1] <= integ_q[1] + integ_q[0];
                integ_q[2] <= int3_d;
                dec_q      <= dec_q + 6'd1;
            end
            if (wrap) acc_q <= int3_d;

            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], wrap};
            for (int k = 0; k < STAGES; k++) begin
                if (vld_pipe_q[k]) begin
                    acc_q    <= acc_q - dly_q[k];
                    dly_q[k] <= acc_q;
                end
            end
            // The first three results still carry the start-up transient.
            if (vld_pipe_q[STAGES]) begin
                dly_q[STAGES] <= acc_q;
                if (warm_q == 2'd3) begin
                    pcm_q <= sat_d;
                    stb_q <= 1'b1;
                end else begin
                    warm_q <= warm_q + 2'd1;
                end
            end
        end
    end

    assign bus.pdm_clk = pclk_q;
    assign bus.pcm_out = pcm_q;
    assign bus.pcm_stb = stb_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: bit clock, warm-up, DC levels, patterns, abort and reset.
module tb_pdm_cic_decimator;
    localparam int PH = 8;
    localparam int P  = 128 * PH;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic en = 1'b0;

    pdm_cic_decimator_if bus();

    pdm_cic_decimator #(.PDM_HALF(PH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bit_idx = 0;
    int ph = 0;
    int en_cyc = 0;
    logic prev_pclk = 1'b0;
    logic [3:0] pat = 4'b0001;
    int pat_len = 1;
    logic glitch = 1'b0;

    // Advance one clock; new PDM bits are driven right after each pdm_clk fall.
    task automatic step();
        logic b;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_pclk && !bus.pdm_clk) begin
            bit_idx++;
            ph = 0;
        end else begin
            ph++;
        end
        prev_pclk = bus.pdm_clk;
        b = pat[bit_idx % pat_len];
        if (glitch && !bus.pdm_clk && ph < PH - 1) b = ~b;
        bus.pdm_data = b;
    endtask

    task automatic wait_stb(input int max, output bit found, output int n, output bit held);
        int v0;
        v0 = int'(bus.pcm_out);
        found = 1'b0;
        held = 1'b1;
        n = 0;
        while (n < max && !found) begin
            step();
            n++;
            if (bus.pcm_stb) found = 1'b1;
            else if (int'(bus.pcm_out) != v0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        bus.pdm_data = 1'b0;
        #1;
        checks++;
        if (bus.pdm_clk !== 1'b0) begin errors++; $display("FAIL rst_pdm_clk: got %b want 0", bus.pdm_clk); end
        checks++;
        if (bus.pcm_out !== 16'sd0) begin errors++; $display("FAIL rst_pcm_out: got %0d want 0", bus.pcm_out); end
        checks++;
        if (bus.pcm_stb !== 1'b0) begin errors++; $display("FAIL rst_pcm_stb: got %b want 0", bus.pcm_stb); end
        repeat (3) step();
        rstn = 1'b1;
        repeat (6) step();
        checks++;
        if (bus.pdm_clk !== 1'b0) begin errors++; $display("FAIL idle_pdm_clk: got %b want 0", bus.pdm_clk); end
    endtask

    task automatic test_pdm_clk();
        int n, h, l;
        pat = 4'b0001; pat_len = 1;
        en = 1'b1;
        en_cyc = cyc;
        n = 0;
        while (!bus.pdm_clk && n < 4 * PH) begin step(); n++; end
        checks++;
        if (n != PH) begin errors++; $display("FAIL first_rise: got %0d want %0d", n, PH); end
        h = 0;
        while (bus.pdm_clk && h < 4 * PH) begin step(); h++; end
        checks++;
        if (h != PH) begin errors++; $display("FAIL high_len: got %0d want %0d", h, PH); end
        l = 0;
        while (!bus.pdm_clk && l < 4 * PH) begin step(); l++; end
        checks++;
        if (l != PH) begin errors++; $display("FAIL low_len: got %0d want %0d", l, PH); end
    endtask

    // Constant ones with the data line glitched low for most of every low phase.
    task automatic test_const_one();
        bit found, held;
        int n, lat;
        glitch = 1'b1;
        wait_stb(4 * P + PH + 40, found, n, held);
        lat = cyc - en_cyc;
        checks++;
        if (!found || lat < 4 * P || lat > 4 * P + PH + 8) begin
            errors++; $display("FAIL one_first_lat: got %0d want %0d..%0d", lat, 4 * P, 4 * P + PH + 8);
        end
        checks++;
        if (int'(bus.pcm_out) != 32767) begin errors++; $display("FAIL one_val0: got %0d want 32767", bus.pcm_out); end
        wait_stb(P + 10, found, n, held);
        checks++;
        if (!found || n != P) begin errors++; $display("FAIL one_period: got %0d want %0d", n, P); end
        checks++;
        if (int'(bus.pcm_out) != 32767) begin errors++; $display("FAIL one_val1: got %0d want 32767", bus.pcm_out); end
        glitch = 1'b0;
    endtask

    task automatic test_const_zero();
        bit found, held;
        int n, lat;
        en = 1'b0;
        step(); step();
        checks++;
        if (bus.pdm_clk !== 1'b0) begin errors++; $display("FAIL dis_pdm_clk: got %b want 0", bus.pdm_clk); end
        pat = 4'b0000; pat_len = 1;
        en = 1'b1;
        en_cyc = cyc;
        wait_stb(4 * P + PH + 40, found, n, held);
        lat = cyc - en_cyc;
        checks++;
        if (!found || lat < 4 * P || lat > 4 * P + PH + 8) begin
            errors++; $display("FAIL zero_first_lat: got %0d want %0d..%0d", lat, 4 * P, 4 * P + PH + 8);
        end
        checks++;
        if (!held) begin errors++; $display("FAIL zero_warm_hold: got changed want held"); end
        checks++;
        if (int'(bus.pcm_out) != -32768) begin errors++; $display("FAIL zero_val0: got %0d want -32768", bus.pcm_out); end
        wait_stb(P + 10, found, n, held);
        checks++;
        if (!found || int'(bus.pcm_out) != -32768) begin
            errors++; $display("FAIL zero_val1: got %0d found %0d want -32768", bus.pcm_out, found);
        end
    endtask

    task automatic test_en_abort();
        bit found, held, lowok;
        int n, lat, stbs;
        wait_stb(P + 10, found, n, held);
        checks++;
        if (!found || n != P) begin errors++; $display("FAIL abort_sync: got %0d want %0d", n, P); end
        repeat (P - 2) step();
        en = 1'b0;
        stbs = 0; lowok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.pcm_stb) stbs++;
            if (bus.pdm_clk !== 1'b0) lowok = 1'b0;
        end
        checks++;
        if (stbs != 0) begin errors++; $display("FAIL abort_stb: got %0d want 0", stbs); end
        checks++;
        if (!lowok) begin errors++; $display("FAIL abort_pdm_clk: got high want low"); end
        checks++;
        if (int'(bus.pcm_out) != -32768) begin errors++; $display("FAIL abort_hold: got %0d want -32768", bus.pcm_out); end
        pat = 4'b0001; pat_len = 1;
        en = 1'b1;
        en_cyc = cyc;
        wait_stb(4 * P + PH + 40, found, n, held);
        lat = cyc - en_cyc;
        checks++;
        if (!found || lat < 4 * P || lat > 4 * P + PH + 8) begin
            errors++; $display("FAIL reen_lat: got %0d want %0d..%0d", lat, 4 * P, 4 * P + PH + 8);
        end
        checks++;
        if (!held) begin errors++; $display("FAIL reen_warm_hold: got changed want held"); end
        checks++;
        if (int'(bus.pcm_out) != 32767) begin errors++; $display("FAIL reen_val: got %0d want 32767", bus.pcm_out); end
    endtask

    // Switch pattern on the fly; the 4th and 5th strobes are past the filter memory.
    task automatic test_pattern(input logic [3:0] p, input int len, input int want, input string nm);
        bit found, held;
        int n;
        pat = p; pat_len = len;
        for (int k = 1; k <= 5; k++) begin
            wait_stb(P + 10, found, n, held);
            if (k >= 4) begin
                checks++;
                if (!found || int'(bus.pcm_out) != want) begin
                    errors++; $display("FAIL %s_s%0d: got %0d found %0d want %0d", nm, k, bus.pcm_out, found, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found, held;
        int n, lat, stbs;
        pat = 4'b0001; pat_len = 1;
        n = 0;
        while (!bus.pdm_clk && n < 4 * PH) begin step(); n++; end
        step(); step();
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.pdm_clk !== 1'b0) begin errors++; $display("FAIL mid_pdm_clk: got %b want 0", bus.pdm_clk); end
        checks++;
        if (bus.pcm_out !== 16'sd0) begin errors++; $display("FAIL mid_pcm_out: got %0d want 0", bus.pcm_out); end
        stbs = 0;
        for (int i = 0; i < 4; i++) begin step(); if (bus.pcm_stb) stbs++; end
        checks++;
        if (stbs != 0) begin errors++; $display("FAIL mid_stb: got %0d want 0", stbs); end
        rstn = 1'b1;
        en_cyc = cyc;
        wait_stb(4 * P + PH + 40, found, n, held);
        lat = cyc - en_cyc;
        checks++;
        if (!found || lat < 4 * P || lat > 4 * P + PH + 10) begin
            errors++; $display("FAIL mid_lat: got %0d want %0d..%0d", lat, 4 * P, 4 * P + PH + 10);
        end
        checks++;
        if (int'(bus.pcm_out) != 32767) begin errors++; $display("FAIL mid_val: got %0d want 32767", bus.pcm_out); end
    endtask

    initial begin
        bus.pdm_data = 1'b0;
        test_reset();
        test_pdm_clk();
        test_const_one();
        test_const_zero();
        test_en_abort();
        test_pattern(4'b0001, 2, 0, "alt");
        test_pattern(4'b0001, 4, -16384, "quarter");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
